// File: rtl/muxpga_fabric_v2_if.sv
// Config shift-chain handshake bundle for the mux-cell fabric.
// Carries the valid/ready beat, its payload and the chain tail readback.
interface muxpga_fabric_v2_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_data;
    logic       cfg_recirc;
    logic [3:0] cfg_tail;

    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_recirc,
        input  cfg_ready,
        input  cfg_tail
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_recirc,
        output cfg_ready,
        output cfg_tail
    );
endinterface

// File: rtl/muxpga_fabric_v2.sv
// Second-generation mux-cell torus fabric with a config shift chain,
// recirculating readback and a run controller with auto-stop.
module muxpga_fabric_v2 #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int B     = 2,
    parameter int CNT_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    muxpga_fabric_v2_if.slave   cfg_if,
    input  logic                i_start,
    input  logic                i_halt,
    input  logic [CNT_W-1:0]    i_run_limit,
    input  logic [COLS*B-1:0]   i_ext_in,
    output logic [COLS*B-1:0]   o_top_q,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_cycle_cnt,
    output logic                o_done,
    output logic                o_err
);

    localparam int N  = ROWS * COLS;
    localparam int LW = $clog2(N + 1);
    localparam logic [LW-1:0] LOAD_FULL = LW'(N);

    typedef enum logic {
        S_CFG = 1'b0,
        S_RUN = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [N-1:0][3:0]       r_cfg;
    logic [N-1:0][B-1:0]     r_q;
    logic [N-1:0][B-1:0]     w_q_nxt;
    logic [LW-1:0]           r_load_cnt;
    logic [CNT_W-1:0]        r_cycle_cnt;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    r_done;
    logic                    r_err;

    logic                    w_beat;
    logic [3:0]              w_head;
    logic                    w_start_ok;
    logic                    w_start_err;
    logic                    w_tick;
    logic                    w_auto;

    assign w_cnt_inc = r_cycle_cnt + 1'b1;
    assign w_head    = cfg_if.cfg_recirc ? r_cfg[N-1] : cfg_if.cfg_data;

    // Controller decode: handshake, start/halt arbitration, auto-stop
    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_start_ok  = 1'b0;
        w_start_err = 1'b0;
        w_tick      = 1'b0;
        w_auto      = 1'b0;
        unique case (r_state)
            S_CFG: begin
                w_beat = cfg_if.cfg_valid;
                if (i_start && !i_halt) begin
                    if (r_load_cnt == LOAD_FULL) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_start_err = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (i_halt) begin
                    w_state_nxt = S_CFG;
                end else begin
                    w_tick = 1'b1;
                    if ((i_run_limit != '0) && (w_cnt_inc == i_run_limit)) begin
                        w_auto      = 1'b1;
                        w_state_nxt = S_CFG;
                    end
                end
            end
            default: w_state_nxt = S_CFG;
        endcase
    end

    // Controller state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_CFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-cell neighbour select and next-value logic
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int I  = r * COLS + c;
            localparam int IW = r * COLS + ((c + COLS - 1) % COLS);
            localparam int IE = r * COLS + ((c + 1) % COLS);
            localparam int IS = (r == 0) ? I : (r - 1) * COLS + c;
            localparam int IN = (r == ROWS - 1) ? I : (r + 1) * COLS + c;

            logic [B-1:0] w_nb;
            logic [B-1:0] w_nxt;
            logic [B-1:0] w_south;
            logic [B-1:0] w_north;

            if (r == 0) begin : g_s_ext
                assign w_south = i_ext_in[c*B +: B];
            end else begin : g_s_cell
                assign w_south = r_q[IS];
            end

            if (r == ROWS - 1) begin : g_n_zero
                assign w_north = '0;
            end else begin : g_n_cell
                assign w_north = r_q[IN];
            end

            // Neighbour mux by sel, then mode operation
            always_comb begin
                w_nb  = '0;
                w_nxt = r_q[I];
                unique case (r_cfg[I][1:0])
                    2'd0: w_nb = r_q[IW];
                    2'd1: w_nb = r_q[IE];
                    2'd2: w_nb = w_south;
                    2'd3: w_nb = w_north;
                    default: w_nb = '0;
                endcase
                unique case (r_cfg[I][3:2])
                    2'd0: w_nxt = B'(r_cfg[I][1:0]);
                    2'd1: w_nxt = w_nb;
                    2'd2: w_nxt = r_q[I] ^ w_nb;
                    2'd3: w_nxt = ~w_nb;
                    default: w_nxt = r_q[I];
                endcase
            end

            assign w_q_nxt[I] = w_nxt;
        end
    end

    // Datapath registers: chain shift, load count, cells, counter, flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cfg       <= '0;
            r_q         <= '0;
            r_load_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_auto;
            if (w_start_err) begin
                r_err <= 1'b1;
            end
            if (w_beat) begin
                r_cfg <= {r_cfg[N-2:0], w_head};
                if (!cfg_if.cfg_recirc && (r_load_cnt != LOAD_FULL)) begin
                    r_load_cnt <= r_load_cnt + 1'b1;
                end
            end
            if (w_start_ok) begin
                r_q         <= '0;
                r_cycle_cnt <= '0;
            end else if (w_tick) begin
                r_q         <= w_q_nxt;
                r_cycle_cnt <= w_cnt_inc;
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_top
        assign o_top_q[c*B +: B] = r_q[(ROWS - 1) * COLS + c];
    end

    assign cfg_if.cfg_ready = (r_state == S_CFG);
    assign cfg_if.cfg_tail  = r_cfg[N-1];
    assign o_busy           = (r_state == S_RUN);
    assign o_cycle_cnt      = r_cycle_cnt;
    assign o_done           = r_done;
    assign o_err            = r_err;

endmodule

// File: tb/tb_muxpga_fabric_v2.sv
// Directed bench for the 2x2, 2-bit mux-cell fabric.
// Covers reset, chain load/readback, start errors, modes, auto-stop, halt.
module tb_muxpga_fabric_v2;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int B     = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             halt;
    logic [CNT_W-1:0] run_limit;
    logic [3:0]       ext_in;
    logic [3:0]       top_q;
    logic             busy;
    logic [CNT_W-1:0] cycle_cnt;
    logic             done;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    muxpga_fabric_v2_if u_if ();

    muxpga_fabric_v2 #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .B     (B),
        .CNT_W (CNT_W)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .cfg_if      (u_if.slave),
        .i_start     (start),
        .i_halt      (halt),
        .i_run_limit (run_limit),
        .i_ext_in    (ext_in),
        .o_top_q     (top_q),
        .o_busy      (busy),
        .o_cycle_cnt (cycle_cnt),
        .o_done      (done),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic beat(input logic [3:0] d, input logic rc);
        u_if.cfg_valid  = 1'b1;
        u_if.cfg_data   = d;
        u_if.cfg_recirc = rc;
        step();
        u_if.cfg_valid  = 1'b0;
        u_if.cfg_recirc = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        step();
        halt = 1'b0;
    endtask

    task automatic run_cfg(input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
        do_reset();
        beat(d0, 1'b0);
        beat(d1, 1'b0);
        beat(d2, 1'b0);
        beat(d3, 1'b0);
        pulse_start();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_t [4];
        int k;
        exp_t = '{4'h2, 4'h3, 4'h4, 4'h1};
        rst_n           = 1'b1;
        start           = 1'b0;
        halt            = 1'b0;
        run_limit       = '0;
        ext_in          = 4'b1101;
        u_if.cfg_valid  = 1'b0;
        u_if.cfg_data   = '0;
        u_if.cfg_recirc = 1'b0;

        // reset state
        do_reset();
        check("rst_ready", u_if.cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_top_q", top_q, 0);
        check("rst_tail", u_if.cfg_tail, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_cnt", cycle_cnt, 0);

        // early start, then complete load
        beat(4'h1, 1'b0);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        pulse_start();
        check("early_err", err, 1);
        check("early_busy", busy, 0);
        beat(4'h4, 1'b0);
        check("load_tail", u_if.cfg_tail, 4'h1);

        // non-destructive readback by recirculation
        for (int i = 0; i < 4; i++) begin
            beat(4'hF, 1'b1);
            check($sformatf("recirc_tail%0d", i), u_if.cfg_tail, exp_t[i]);
        end

        pulse_start();
        check("start_busy", busy, 1);
        check("run_ready", u_if.cfg_ready, 0);
        check("err_sticky", err, 1);
        beat(4'hF, 1'b0);
        check("run_no_beat", u_if.cfg_tail, 4'h1);
        do_halt();
        check("halt_busy", busy, 0);

        // start and halt together: halt wins
        start = 1'b1;
        halt  = 1'b1;
        step();
        start = 1'b0;
        halt  = 1'b0;
        check("st_halt_busy", busy, 0);

        // propagation of ext_in through pass-south cells
        run_limit = '0;
        ext_in    = 4'b1101;
        run_cfg(4'h6, 4'h6, 4'h6, 4'h6);
        check("prop_err", err, 0);
        check("prop_busy", busy, 1);
        check("prop_q0", top_q, 0);
        step();
        check("prop_q1", top_q, 0);
        step();
        check("prop_q2", top_q, 4'b1101);
        step();
        check("prop_q3", top_q, 4'b1101);
        do_halt();

        // auto-stop at run_limit=3
        run_limit = 8'd3;
        pulse_start();
        check("as_busy", busy, 1);
        check("as_cnt0", cycle_cnt, 0);
        step();
        check("as_cnt1", cycle_cnt, 1);
        step();
        check("as_cnt2", cycle_cnt, 2);
        check("as_done2", done, 0);
        step();
        check("as_done", done, 1);
        check("as_cnt3", cycle_cnt, 3);
        check("as_busy3", busy, 0);
        step();
        check("as_done_pulse", done, 0);
        check("as_cnt_hold", cycle_cnt, 3);

        // restart without reload
        pulse_start();
        check("re_busy", busy, 1);
        check("re_cnt", cycle_cnt, 0);
        check("re_q", top_q, 0);
        k = 0;
        while (!done && k < 20) begin
            step();
            k++;
        end
        check("re_done_cycles", k, 3);

        // halt at cycle_cnt=5
        run_limit = '0;
        pulse_start();
        repeat (5) step();
        check("h_cnt5", cycle_cnt, 5);
        do_halt();
        check("h_busy", busy, 0);
        check("h_cnt", cycle_cnt, 5);
        check("h_done", done, 0);
        step();
        check("h_cnt_hold", cycle_cnt, 5);

        // reset mid-run
        pulse_start();
        step();
        step();
        check("mr_q", top_q, 4'b1101);
        do_reset();
        check("mr_ready", u_if.cfg_ready, 1);
        check("mr_busy", busy, 0);
        check("mr_top_q", top_q, 0);
        check("mr_tail", u_if.cfg_tail, 0);
        check("mr_err", err, 0);
        check("mr_cnt", cycle_cnt, 0);
        pulse_start();
        check("mr_err_start", err, 1);
        check("mr_busy_start", busy, 0);

        // mode 3 invert, north neighbour (top row sees 0)
        run_cfg(4'hF, 4'hF, 4'hF, 4'hF);
        step();
        check("inv_q1", top_q, 4'b1111);

        // mode 2 xor with south neighbour
        run_cfg(4'hA, 4'hA, 4'hA, 4'hA);
        step();
        step();
        check("xor_q2", top_q, 4'b1101);
        step();
        step();
        check("xor_q4", top_q, 4'b0000);

        // mode 0 constant
        run_cfg(4'h2, 4'h2, 4'h2, 4'h2);
        step();
        check("const_q1", top_q, 4'b1010);

        // west neighbour wrap
        run_cfg(4'h4, 4'h1, 4'h0, 4'h0);
        step();
        check("west_q1", top_q, 4'b0001);
        step();
        check("west_q2", top_q, 4'b0101);

        // east neighbour wrap
        run_cfg(4'h3, 4'h5, 4'h0, 4'h0);
        step();
        check("east_q1", top_q, 4'b1100);
        step();
        check("east_q2", top_q, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
